game_flow_ctrl: RTL and testbench

- Top-level game sequencer for the H.E.R.O. build. Sits between the player movement/collision logic and the display/HUD.
- Owns the game state machine: title, play, death, level clear, game over and win.
- Tracks lives, the energy (power) bar, the current level and the score.
- Drives `freeze` and a one-cycle `respawn` pulse that the movement logic uses to halt the hero and reposition it.

---
 rtl/game_flow_ctrl.sv | 171 +++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Game sequencer: title/play/death/clear/over/win FSM with lives, energy, level and score.
// All outputs registered; PLAY transition conditions appear on state/freeze one edge later.
module game_flow_ctrl #(
    parameter int LIVES_INIT = 3,
    parameter int ENERGY_MAX = 200,
    parameter int ENERGY_DIV = 8,
    parameter int DEATH_HOLD = 60,
    parameter int CLEAR_HOLD = 120,
    parameter int MINER_PTS  = 1000,
    parameter int LEVELS     = 4
) (
    input  logic        clk_char,
    input  logic        rst,
    input  logic        start_n,
    input  logic [15:0] death_flag,
    input  logic        coll_miner,
    input  logic        win_flag,
    output logic [2:0]  state,
    output logic        freeze,
    output logic        respawn,
    output logic [1:0]  lives,
    output logic [3:0]  level,
    output logic [7:0]  energy,
    output logic [15:0] score
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_DYING = 3'd2,
        S_CLEAR = 3'd3,
        S_OVER  = 3'd4,
        S_WIN   = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic        freeze_q, freeze_d;
    logic        respawn_q, respawn_d;
    logic [1:0]  lives_q, lives_d;
    logic [3:0]  level_q, level_d;
    logic [7:0]  energy_q, energy_d;
    logic [15:0] score_q, score_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] div_q, div_d;
    logic        start_q, start_d;
    logic        miner_q, miner_d;

    logic        start_press;
    logic        miner_rise;
    logic [16:0] score_sum;

    assign start_press = start_q & ~start_n;
    assign miner_rise  = coll_miner & ~miner_q;
    assign score_sum   = {1'b0, score_q} + 17'(MINER_PTS) + {9'b0, energy_q};

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        level_d   = level_q;
        energy_d  = energy_q;
        score_d   = score_q;
        hold_d    = hold_q;
        div_d     = div_q;
        respawn_d = 1'b0;
        start_d   = start_n;
        miner_d   = coll_miner;

        case (state_q)
            S_IDLE: begin
                if (start_press) begin
                    lives_d   = 2'(LIVES_INIT);
                    score_d   = '0;
                    level_d   = '0;
                    energy_d  = 8'(ENERGY_MAX);
                    div_d     = '0;
                    respawn_d = 1'b1;
                    state_d   = S_PLAY;
                end
            end
            S_PLAY: begin
                if (win_flag) begin
                    state_d = S_WIN;
                end else if ((|death_flag) || energy_q == 8'd0) begin
                    state_d = S_DYING;
                end else if (miner_rise) begin
                    score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    state_d = S_CLEAR;
                end else if (div_q == 16'(ENERGY_DIV - 1)) begin
                    div_d    = '0;
                    energy_d = energy_q - 8'd1;
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            S_DYING: begin
                hold_d = hold_q + 16'd1;
                if (hold_q == 16'(DEATH_HOLD - 1)) begin
                    if (lives_q <= 2'd1) begin
                        lives_d = 2'd0;
                        state_d = S_OVER;
                    end else begin
                        lives_d   = lives_q - 2'd1;
                        energy_d  = 8'(ENERGY_MAX);
                        div_d     = '0;
                        respawn_d = 1'b1;
                        state_d   = S_PLAY;
                    end
                end
            end
            S_CLEAR: begin
                hold_d = hold_q + 16'd1;
                if (hold_q == 16'(CLEAR_HOLD - 1)) begin
                    if (level_q == 4'(LEVELS - 1)) begin
                        state_d = S_WIN;
                    end else begin
                        level_d   = level_q + 4'd1;
                        energy_d  = 8'(ENERGY_MAX);
                        div_d     = '0;
                        respawn_d = 1'b1;
                        state_d   = S_PLAY;
                    end
                end
            end
            S_OVER, S_WIN: begin
                if (start_press) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Every state entry starts its hold window from zero.
        if (state_d != state_q) hold_d = '0;
        freeze_d = (state_d != S_PLAY);
    end

    always_ff @(posedge clk_char or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            freeze_q  <= 1'b1;
            respawn_q <= 1'b0;
            lives_q   <= '0;
            level_q   <= '0;
            energy_q  <= '0;
            score_q   <= '0;
            hold_q    <= '0;
            div_q     <= '0;
            start_q   <= 1'b1;
            miner_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            freeze_q  <= freeze_d;
            respawn_q <= respawn_d;
            lives_q   <= lives_d;
            level_q   <= level_d;
            energy_q  <= energy_d;
            score_q   <= score_d;
            hold_q    <= hold_d;
            div_q     <= div_d;
            start_q   <= start_d;
            miner_q   <= miner_d;
        end
    end

    assign state   = state_q;
    assign freeze  = freeze_q;
    assign respawn = respawn_q;
    assign lives   = lives_q;
    assign level   = level_q;
    assign energy  = energy_q;
    assign score   = score_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios plus a random run against a game-rules model.
module tb_game_flow_ctrl;

    localparam int LIVES_INIT = 3;
    localparam int ENERGY_MAX = 200;
    localparam int ENERGY_DIV = 8;
    localparam int DEATH_HOLD = 60;
    localparam int CLEAR_HOLD = 120;
    localparam int MINER_PTS  = 1000;
    localparam int LEVELS     = 4;

    localparam int ST_IDLE = 0, ST_PLAY = 1, ST_DYING = 2, ST_CLEAR = 3, ST_OVER = 4, ST_WIN = 5;

    logic        clk_char = 1'b0;
    logic        rst = 1'b1;
    logic        start_n = 1'b1;
    logic [15:0] death_flag = '0;
    logic        coll_miner = 1'b0;
    logic        win_flag = 1'b0;
    logic [2:0]  state;
    logic        freeze;
    logic        respawn;
    logic [1:0]  lives;
    logic [3:0]  level;
    logic [7:0]  energy;
    logic [15:0] score;

    int checks = 0;
    int errors = 0;

    game_flow_ctrl dut (
        .clk_char  (clk_char),
        .rst       (rst),
        .start_n   (start_n),
        .death_flag(death_flag),
        .coll_miner(coll_miner),
        .win_flag  (win_flag),
        .state     (state),
        .freeze    (freeze),
        .respawn   (respawn),
        .lives     (lives),
        .level     (level),
        .energy    (energy),
        .score     (score)
    );

    always #5 clk_char = ~clk_char;

    // Game-rules model: energy is derived from how many play ticks have elapsed
    // since the last reload, holds are measured as cycles spent in the state.
    int m_state, m_lives, m_level, m_score, m_play_ticks, m_in_state;
    bit m_loaded, m_respawn, m_prev_start, m_prev_miner;

    function automatic int m_energy();
        int used;
        if (!m_loaded) return 0;
        used = m_play_ticks / ENERGY_DIV;
        return (used >= ENERGY_MAX) ? 0 : ENERGY_MAX - used;
    endfunction

    task automatic model_reset();
        m_state = ST_IDLE; m_lives = 0; m_level = 0; m_score = 0;
        m_play_ticks = 0; m_in_state = 0; m_loaded = 0; m_respawn = 0;
        m_prev_start = 1; m_prev_miner = 0;
    endtask

    task automatic model_step();
        bit press, rise;
        int nxt;
        press = m_prev_start && !start_n;
        rise  = coll_miner && !m_prev_miner;
        nxt = m_state;
        m_respawn = 0;
        case (m_state)
            ST_IDLE: if (press) begin
                m_lives = LIVES_INIT; m_score = 0; m_level = 0;
                m_play_ticks = 0; m_loaded = 1; m_respawn = 1; nxt = ST_PLAY;
            end
            ST_PLAY: begin
                if (win_flag) nxt = ST_WIN;
                else if (death_flag != 0 || m_energy() == 0) nxt = ST_DYING;
                else if (rise) begin
                    m_score = m_score + MINER_PTS + m_energy();
                    if (m_score > 65535) m_score = 65535;
                    nxt = ST_CLEAR;
                end else m_play_ticks++;
            end
            ST_DYING: if (m_in_state == DEATH_HOLD - 1) begin
                if (m_lives <= 1) begin m_lives = 0; nxt = ST_OVER; end
                else begin m_lives--; m_play_ticks = 0; m_respawn = 1; nxt = ST_PLAY; end
            end
            ST_CLEAR: if (m_in_state == CLEAR_HOLD - 1) begin
                if (m_level == LEVELS - 1) nxt = ST_WIN;
                else begin m_level++; m_play_ticks = 0; m_respawn = 1; nxt = ST_PLAY; end
            end
            default: if (press) nxt = ST_IDLE;
        endcase
        m_in_state = (nxt != m_state) ? 0 : m_in_state + 1;
        m_state = nxt;
        m_prev_start = start_n;
        m_prev_miner = coll_miner;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_char);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (freeze !== 1'b1 || respawn !== 1'b0) begin errors++; $display("FAIL reset_flags got f=%0b r=%0b want f=1 r=0", freeze, respawn); end
        checks++; if ({lives, level, energy, score} !== 30'd0) begin errors++; $display("FAIL reset_regs got l=%0d lv=%0d e=%0d s=%0d want 0", lives, level, energy, score); end
        rst = 1'b0;
        model_reset();
        tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL idle_hold got %0d want 0", state); end
    endtask

    task automatic test_start();
        start_n = 1'b0;
        tick();
        start_n = 1'b1;
        checks++; if (state !== 3'd1 || freeze !== 1'b0 || respawn !== 1'b1) begin errors++; $display("FAIL start_state got s=%0d f=%0b r=%0b want s=1 f=0 r=1", state, freeze, respawn); end
        checks++; if (lives !== 2'd3 || energy !== 8'd200 || score !== 16'd0 || level !== 4'd0) begin errors++; $display("FAIL start_regs got l=%0d e=%0d s=%0d lv=%0d want 3/200/0/0", lives, energy, score, level); end
        tick();
        checks++; if (respawn !== 1'b0 || state !== 3'd1) begin errors++; $display("FAIL respawn_pulse got r=%0b s=%0d want r=0 s=1", respawn, state); end
    endtask

    task automatic test_energy();
        repeat (79) tick();
        checks++; if (energy !== 8'd190) begin errors++; $display("FAIL energy_80 got %0d want 190", energy); end
        repeat (1520) tick();
        checks++; if (energy !== 8'd0 || state !== 3'd1) begin errors++; $display("FAIL energy_empty got e=%0d s=%0d want e=0 s=1", energy, state); end
        tick();
        checks++; if (state !== 3'd2 || freeze !== 1'b1) begin errors++; $display("FAIL energy_death got s=%0d f=%0b want s=2 f=1", state, freeze); end
    endtask

    task automatic test_death();
        for (int d = 0; d < 3; d++) begin
            if (d > 0) begin
                death_flag = 16'h0004;
                tick();
                death_flag = '0;
                checks++; if (state !== 3'd2 || freeze !== 1'b1 || respawn !== 1'b0) begin errors++; $display("FAIL death_enter%0d got s=%0d f=%0b r=%0b want 2/1/0", d, state, freeze, respawn); end
            end
            for (int c = 1; c < DEATH_HOLD; c++) begin
                tick();
                checks++; if (state !== 3'd2) begin errors++; $display("FAIL death_hold%0d cyc %0d got %0d want 2", d, c, state); end
            end
            tick();
            if (d < 2) begin
                checks++; if (state !== 3'd1 || lives !== 2'(2 - d) || energy !== 8'd200 || respawn !== 1'b1) begin
                    errors++; $display("FAIL death_respawn%0d got s=%0d l=%0d e=%0d r=%0b want 1/%0d/200/1", d, state, lives, energy, respawn, 2 - d);
                end
            end else begin
                checks++; if (state !== 3'd4 || lives !== 2'd0 || freeze !== 1'b1) begin errors++; $display("FAIL game_over got s=%0d l=%0d f=%0b want 4/0/1", state, lives, freeze); end
            end
        end
        start_n = 1'b0;
        tick();
        start_n = 1'b1;
        checks++; if (state !== 3'd0 || freeze !== 1'b1) begin errors++; $display("FAIL over_to_idle got s=%0d f=%0b want 0/1", state, freeze); end
        tick();
    endtask

    task automatic test_miner();
        start_n = 1'b0;
        tick();
        start_n = 1'b1;
        repeat (400) tick();
        checks++; if (energy !== 8'd150) begin errors++; $display("FAIL miner_energy got %0d want 150", energy); end
        coll_miner = 1'b1;
        tick();
        checks++; if (state !== 3'd3 || score !== 16'd1150 || freeze !== 1'b1) begin errors++; $display("FAIL miner_clear got s=%0d sc=%0d f=%0b want 3/1150/1", state, score, freeze); end
        repeat (4) begin
            tick();
            checks++; if (state !== 3'd3 || score !== 16'd1150) begin errors++; $display("FAIL miner_single got s=%0d sc=%0d want 3/1150", state, score); end
        end
        coll_miner = 1'b0;
        repeat (CLEAR_HOLD - 5) tick();
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL clear_hold got %0d want 3", state); end
        tick();
        checks++; if (state !== 3'd1 || level !== 4'd1 || energy !== 8'd200 || respawn !== 1'b1) begin errors++; $display("FAIL clear_next got s=%0d lv=%0d e=%0d r=%0b want 1/1/200/1", state, level, energy, respawn); end
    endtask

    task automatic test_priority();
        start_n = 1'b0;
        tick();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL play_ignores_start got %0d want 1", state); end
        win_flag = 1'b1; death_flag = 16'h8001; coll_miner = 1'b1;
        tick();
        win_flag = 1'b0; death_flag = '0; coll_miner = 1'b0;
        checks++; if (state !== 3'd5 || score !== 16'd1150 || lives !== 2'd3 || level !== 4'd1) begin errors++; $display("FAIL win_priority got s=%0d sc=%0d l=%0d lv=%0d want 5/1150/3/1", state, score, lives, level); end
        repeat (5) tick();
        checks++; if (state !== 3'd5) begin errors++; $display("FAIL held_start got %0d want 5", state); end
        start_n = 1'b1;
        tick();
        checks++; if (state !== 3'd5) begin errors++; $display("FAIL release got %0d want 5", state); end
        start_n = 1'b0;
        tick();
        start_n = 1'b1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL win_restart got %0d want 0", state); end
        tick();
    endtask

    task automatic test_last_level();
        start_n = 1'b0;
        tick();
        start_n = 1'b1;
        for (int lv = 0; lv < LEVELS; lv++) begin
            coll_miner = 1'b1;
            tick();
            coll_miner = 1'b0;
            checks++; if (state !== 3'd3 || score !== 16'((lv + 1) * (MINER_PTS + ENERGY_MAX))) begin
                errors++; $display("FAIL lvl_clear%0d got s=%0d sc=%0d want 3/%0d", lv, state, score, (lv + 1) * (MINER_PTS + ENERGY_MAX));
            end
            repeat (CLEAR_HOLD) tick();
            if (lv < LEVELS - 1) begin
                checks++; if (state !== 3'd1 || level !== 4'(lv + 1)) begin errors++; $display("FAIL lvl_next%0d got s=%0d lv=%0d want 1/%0d", lv, state, level, lv + 1); end
            end else begin
                checks++; if (state !== 3'd5 || level !== 4'd3) begin errors++; $display("FAIL last_level_win got s=%0d lv=%0d want 5/3", state, level); end
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        start_n = 1'b0; tick(); start_n = 1'b1; tick();
        start_n = 1'b0; tick(); start_n = 1'b1;
        death_flag = 16'h0100; tick(); death_flag = '0;
        repeat (10) tick();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL pre_reset_dying got %0d want 2", state); end
        #3 rst = 1'b1;
        #1;
        checks++; if (state !== 3'd0 || freeze !== 1'b1 || respawn !== 1'b0 || {lives, level, energy, score} !== 30'd0) begin
            errors++; $display("FAIL async_reset got s=%0d f=%0b r=%0b l=%0d lv=%0d e=%0d sc=%0d want all reset", state, freeze, respawn, lives, level, energy, score);
        end
        #2 rst = 1'b0;
        model_reset();
        repeat (DEATH_HOLD + 2) tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL hold_aborted got %0d want 0", state); end
    endtask

    task automatic test_random();
        @(negedge clk_char);
        rst = 1'b1; start_n = 1'b1; death_flag = '0; coll_miner = 1'b0; win_flag = 1'b0;
        #2 rst = 1'b0;
        model_reset();
        @(posedge clk_char); #1;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 11) == 0) start_n = ~start_n;
            if ($urandom_range(0, 29) == 0) coll_miner = ~coll_miner;
            death_flag = ($urandom_range(0, 399) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'd0;
            win_flag = ($urandom_range(0, 2999) == 0);
            tick();
            checks++; if (state !== 3'(m_state) || freeze !== (m_state != ST_PLAY) || respawn !== m_respawn) begin
                errors++; $display("FAIL rnd_state cyc %0d got s=%0d f=%0b r=%0b want s=%0d r=%0b", i, state, freeze, respawn, m_state, m_respawn);
            end
            checks++; if (lives !== 2'(m_lives) || level !== 4'(m_level) || energy !== 8'(m_energy()) || score !== 16'(m_score)) begin
                errors++; $display("FAIL rnd_regs cyc %0d got l=%0d lv=%0d e=%0d sc=%0d want %0d/%0d/%0d/%0d", i, lives, level, energy, score, m_lives, m_level, m_energy(), m_score);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_energy();
        test_death();
        test_miner();
        test_priority();
        test_last_level();
        test_reset_mid_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
